mc_ctrl: RTL and testbench

Multicycle MIPS control unit that sits directly upstream of the datapath. It decodes the latched instruction fields `op`/`funct` and the ALU `zero` flag. Each cycle it drives every datapath control line (PC/IR/RF/DM write enables, mux selects, ALU/EXT/NPC opcodes) from a Moore state machine, with a single Mealy term for branches. Supported instructions: addu, subu, jr, ori, lui, lw, sw, beq, j, jal.

---
 rtl/mc_pkg.sv | 55 +++++
 rtl/mc_decode.sv | 30 +++
 rtl/mc_ctrl.sv | 143 ++++++++++++++
 tb/tb_mc_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS controller and its datapath.
package mc_pkg;

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DCD     = 4'd1;
    localparam logic [3:0] S_EXE     = 4'd2;
    localparam logic [3:0] S_ALU_WB  = 4'd3;
    localparam logic [3:0] S_MEM_ADR = 4'd4;
    localparam logic [3:0] S_MEM_RD  = 4'd5;
    localparam logic [3:0] S_MEM_WB  = 4'd6;
    localparam logic [3:0] S_MEM_WR  = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_JUMP    = 4'd9;

    typedef enum logic [3:0] {
        CL_RTYPE_ALU, CL_IMM_ALU, CL_LOAD, CL_STORE, CL_BRANCH,
        CL_JMP, CL_JAL, CL_JR, CL_ILLEGAL
    } iclass_t;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_LUI = 6'b001111;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_JR   = 6'b001000;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_OR    = 4'b0010;
    localparam logic [3:0] ALU_PASSB = 4'b0011;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_HI   = 2'b10;

    localparam logic [1:0] NPC_PC4 = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;
    localparam logic [1:0] NPC_JR  = 2'b11;

    localparam logic [1:0] RSEL_RT = 2'b00;
    localparam logic [1:0] RSEL_RD = 2'b01;
    localparam logic [1:0] RSEL_31 = 2'b10;

    localparam logic [1:0] DSEL_PC  = 2'b00;
    localparam logic [1:0] DSEL_ALU = 2'b01;
    localparam logic [1:0] DSEL_DM  = 2'b10;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: op/funct -> instruction class.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output iclass_t    cls
);

    always_comb begin
        cls = CL_ILLEGAL;
        case (op)
            OP_R: begin
                case (funct)
                    FN_ADDU, FN_SUBU: cls = CL_RTYPE_ALU;
                    FN_JR:            cls = CL_JR;
                    default:          cls = CL_ILLEGAL;
                endcase
            end
            OP_ORI, OP_LUI: cls = CL_IMM_ALU;
            OP_LW:          cls = CL_LOAD;
            OP_SW:          cls = CL_STORE;
            OP_BEQ:         cls = CL_BRANCH;
            OP_J:           cls = CL_JMP;
            OP_JAL:         cls = CL_JAL;
            default:        cls = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control FSM: Moore outputs per state, PCWr follows zero in BRANCH.
module mc_ctrl
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [1:0] npcop,
    output logic       PCWr,
    output logic       IRWr,
    output logic       RFWr,
    output logic       wren,
    output logic [3:0] aluop,
    output logic [1:0] extop,
    output logic       sel,
    output logic [1:0] R_sel,
    output logic [1:0] D_sel,
    output logic       illegal,
    output logic [3:0] state
);

    iclass_t    cls;
    logic [3:0] nxt;
    logic       pc_wr, ir_wr, rf_wr, dm_wr, ill;
    logic [3:0] ex_alu;
    logic [1:0] ex_ext;
    logic       ex_sel;

    mc_decode u_decode (.op(op), .funct(funct), .cls(cls));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= nxt;
    end

    // ALU controls for the EXE phase; ALU_WB reuses them so the ALU latch stays stable.
    always_comb begin
        ex_alu = ALU_ADD;
        ex_ext = EXT_ZERO;
        ex_sel = 1'b0;
        if (cls == CL_RTYPE_ALU) begin
            ex_alu = (funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
        end else if (op == OP_LUI) begin
            ex_alu = ALU_PASSB;
            ex_ext = EXT_HI;
            ex_sel = 1'b1;
        end else begin
            ex_alu = ALU_OR;
            ex_sel = 1'b1;
        end
    end

    always_comb begin
        nxt   = S_FETCH;
        pc_wr = 1'b0;
        ir_wr = 1'b0;
        rf_wr = 1'b0;
        dm_wr = 1'b0;
        ill   = 1'b0;
        npcop = NPC_PC4;
        aluop = ALU_ADD;
        extop = EXT_ZERO;
        sel   = 1'b0;
        R_sel = RSEL_RT;
        D_sel = DSEL_PC;
        case (state)
            S_FETCH: begin
                ir_wr = 1'b1;
                pc_wr = 1'b1;
                nxt   = S_DCD;
            end
            S_DCD: begin
                case (cls)
                    CL_RTYPE_ALU, CL_IMM_ALU:  nxt = S_EXE;
                    CL_LOAD, CL_STORE:         nxt = S_MEM_ADR;
                    CL_BRANCH:                 nxt = S_BRANCH;
                    CL_JMP, CL_JAL, CL_JR:     nxt = S_JUMP;
                    default: begin
                        nxt = S_FETCH;
                        ill = 1'b1;
                    end
                endcase
            end
            S_EXE: begin
                aluop = ex_alu;
                extop = ex_ext;
                sel   = ex_sel;
                nxt   = S_ALU_WB;
            end
            S_ALU_WB: begin
                aluop = ex_alu;
                extop = ex_ext;
                sel   = ex_sel;
                rf_wr = 1'b1;
                D_sel = DSEL_ALU;
                R_sel = (cls == CL_RTYPE_ALU) ? RSEL_RD : RSEL_RT;
            end
            S_MEM_ADR: begin
                aluop = ALU_ADD;
                sel   = 1'b1;
                extop = EXT_SIGN;
                nxt   = (cls == CL_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: nxt = S_MEM_WB;
            S_MEM_WB: begin
                rf_wr = 1'b1;
                R_sel = RSEL_RT;
                D_sel = DSEL_DM;
            end
            S_MEM_WR: dm_wr = 1'b1;
            S_BRANCH: begin
                aluop = ALU_SUB;
                extop = EXT_SIGN;
                npcop = NPC_BR;
                pc_wr = zero;
            end
            S_JUMP: begin
                pc_wr = 1'b1;
                if (cls == CL_JR) begin
                    npcop = NPC_JR;
                end else begin
                    npcop = NPC_J;
                    if (cls == CL_JAL) begin
                        // pc already holds PC+4, which is the link value
                        rf_wr = 1'b1;
                        R_sel = RSEL_31;
                        D_sel = DSEL_PC;
                    end
                end
            end
            default: nxt = S_FETCH;
        endcase
    end

    assign PCWr    = pc_wr & ~rst;
    assign IRWr    = ir_wr & ~rst;
    assign RFWr    = rf_wr & ~rst;
    assign wren    = dm_wr & ~rst;
    assign illegal = ill   & ~rst;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed + random instruction stream checked cycle-by-cycle against per-instruction traces.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op, funct;
    logic       zero;
    logic [1:0] npcop, extop, R_sel, D_sel;
    logic       PCWr, IRWr, RFWr, wren, sel, illegal;
    logic [3:0] aluop, state;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] st;
        logic [1:0] npc;
        logic       pcwr, irwr, rfwr, wren;
        logic [3:0] alu;
        logic [1:0] ext;
        logic       sel;
        logic [1:0] rs, ds;
        logic       ill;
    } obs_t;

    mc_ctrl dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
        .npcop(npcop), .PCWr(PCWr), .IRWr(IRWr), .RFWr(RFWr), .wren(wren),
        .aluop(aluop), .extop(extop), .sel(sel), .R_sel(R_sel), .D_sel(D_sel),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    function automatic obs_t actual();
        obs_t a;
        a.st = state; a.npc = npcop; a.pcwr = PCWr; a.irwr = IRWr;
        a.rfwr = RFWr; a.wren = wren; a.alu = aluop; a.ext = extop;
        a.sel = sel; a.rs = R_sel; a.ds = D_sel; a.ill = illegal;
        return a;
    endfunction

    function automatic obs_t blank(input logic [3:0] st);
        obs_t e = '0;
        e.st = st;
        return e;
    endfunction

    task automatic check(input string tag, input obs_t exp);
        obs_t a = actual();
        checks++;
        assert (a === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, a, exp);
        end
    endtask

    // Expected per-cycle outputs of one instruction, written from the instruction's semantics.
    task automatic build(input logic [5:0] o, input logic [5:0] f, output obs_t q[$]);
        obs_t e;
        q = {};
        e = blank(0); e.irwr = 1; e.pcwr = 1; q.push_back(e);
        e = blank(1);
        if (o == 6'h00 && (f == 6'h21 || f == 6'h23)) begin
            q.push_back(e);
            e = blank(2); e.alu = (f == 6'h23) ? 4'd1 : 4'd0; q.push_back(e);
            e.st = 3; e.rfwr = 1; e.rs = 2'b01; e.ds = 2'b01; q.push_back(e);
        end else if (o == 6'h0d || o == 6'h0f) begin
            q.push_back(e);
            e = blank(2); e.sel = 1;
            e.alu = (o == 6'h0f) ? 4'd3 : 4'd2;
            e.ext = (o == 6'h0f) ? 2'b10 : 2'b00;
            q.push_back(e);
            e.st = 3; e.rfwr = 1; e.rs = 2'b00; e.ds = 2'b01; q.push_back(e);
        end else if (o == 6'h23 || o == 6'h2b) begin
            q.push_back(e);
            e = blank(4); e.alu = 0; e.sel = 1; e.ext = 2'b01; q.push_back(e);
            if (o == 6'h23) begin
                q.push_back(blank(5));
                e = blank(6); e.rfwr = 1; e.ds = 2'b10; q.push_back(e);
            end else begin
                e = blank(7); e.wren = 1; q.push_back(e);
            end
        end else if (o == 6'h04) begin
            q.push_back(e);
            // pcwr filled in from zero at check time
            e = blank(8); e.alu = 1; e.ext = 2'b01; e.npc = 2'b01; q.push_back(e);
        end else if (o == 6'h02 || o == 6'h03 || (o == 6'h00 && f == 6'h08)) begin
            q.push_back(e);
            e = blank(9); e.pcwr = 1;
            e.npc = (o == 6'h00) ? 2'b11 : 2'b10;
            if (o == 6'h03) begin e.rfwr = 1; e.rs = 2'b10; e.ds = 2'b00; end
            q.push_back(e);
        end else begin
            e.ill = 1; q.push_back(e);
        end
    endtask

    // Runs one instruction from FETCH; zf<0 randomizes zero each cycle; abort_at>=0 asserts rst there.
    task automatic run_instr(input string tag, input logic [5:0] o, input logic [5:0] f,
                             input int zf, input int abort_at);
        obs_t q[$];
        obs_t e;
        build(o, f, q);
        op = o;
        funct = f;
        for (int i = 0; i < q.size(); i++) begin
            zero = (zf < 0) ? 1'($urandom) : 1'(zf);
            #1;
            e = q[i];
            if (e.st == 4'd8) e.pcwr = zero;
            check($sformatf("%s_c%0d", tag, i), e);
            if (i == abort_at) begin
                rst = 1'b1;
                #1;
                check($sformatf("%s_abort", tag), blank(0));
                @(posedge clk);
                @(negedge clk);
                #1;
                check($sformatf("%s_abort_hold", tag), blank(0));
                rst = 1'b0;
                return;
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    logic [5:0] tbl_op [12] = '{6'h00, 6'h00, 6'h00, 6'h0d, 6'h0f, 6'h23,
                                6'h2b, 6'h04, 6'h02, 6'h03, 6'h3f, 6'h00};
    logic [5:0] tbl_fn [12] = '{6'h21, 6'h23, 6'h08, 6'h00, 6'h00, 6'h00,
                                6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h20};

    initial begin
        rst = 1'b1; op = '0; funct = '0; zero = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            check("reset", blank(0));
        end
        rst = 1'b0;

        run_instr("addu", 6'h00, 6'h21, -1, -1);
        run_instr("subu", 6'h00, 6'h23, -1, -1);
        run_instr("ori",  6'h0d, 6'h15, -1, -1);
        run_instr("lui",  6'h0f, 6'h2a, -1, -1);
        run_instr("lw",   6'h23, 6'h00, -1, -1);
        run_instr("sw",   6'h2b, 6'h00, -1, -1);
        run_instr("beq_z1", 6'h04, 6'h00, 1, -1);
        run_instr("beq_z0", 6'h04, 6'h00, 0, -1);
        run_instr("j",    6'h02, 6'h00, -1, -1);
        run_instr("jal",  6'h03, 6'h00, -1, -1);
        run_instr("jr",   6'h00, 6'h08, -1, -1);
        run_instr("ill_op", 6'h3f, 6'h00, -1, -1);
        run_instr("ill_fn", 6'h00, 6'h20, -1, -1);
        run_instr("sw_rst", 6'h2b, 6'h00, -1, 3);
        run_instr("post_rst", 6'h00, 6'h21, -1, -1);

        for (int n = 0; n < 80; n++) begin
            int k;
            logic [5:0] o, f;
            k = $urandom_range(0, 11);
            o = tbl_op[k];
            f = tbl_fn[k];
            if (o != 6'h00) f = 6'($urandom);
            if (k == 10) o = 6'h30 | 6'($urandom_range(0, 15));
            run_instr($sformatf("rnd%0d", n), o, f, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
